// File: rtl/pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher: state encodings, the FSM state
// type and a constant-width helper.
package pulse_stretcher_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        GAP    = ST_GAP
    } state_t;

    // Smallest width w with 2**w >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_stretcher_counter.sv
// Tick counter: counts clock_enable ticks from 0 to HIGH and wraps; tc flags
// the terminal count, sync_reset holds it at zero.
module pulse_stretcher_counter
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clock_enable,
    input  logic sync_reset,
    output logic tc
);

    localparam int CW = (HIGH > 0) ? clog2(HIGH + 1) : 1;
    localparam logic [CW-1:0] HIGH_C = CW'(HIGH);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (sync_reset) begin
            count <= '0;
        end else if (clock_enable) begin
            count <= (count == HIGH_C) ? '0 : count + CW'(1);
        end
    end

    assign tc = (count == HIGH_C);

endmodule

// File: rtl/pulse_stretcher.sv
// Event-driven pulse stretcher: each accepted event yields one HOLD_PERIOD-tick
// active pulse followed by at least GAP_PERIOD inactive ticks.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int   HOLD_PERIOD = 256,
    parameter int   GAP_PERIOD  = 256,
    parameter int   MAX_PENDING = 7,
    parameter logic IDLE_VALUE  = 1'b0,
    localparam int  PW          = clog2(MAX_PENDING + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          event_i,
    output logic          data_o,
    output logic          busy_o,
    output logic [PW-1:0] pending_o,
    output logic          overflow_o
);

    localparam logic [PW-1:0] MAX_C = PW'(MAX_PENDING);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pending;
    logic [PW-1:0] pending_next;
    logic          overflow;
    logic          drop;
    logic          consume;
    logic          request;
    logic          hold_tc;
    logic          gap_tc;

    pulse_stretcher_counter #(
        .HIGH (HOLD_PERIOD - 1)
    ) hold_counter (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (enable),
        .sync_reset   (state != ACTIVE),
        .tc           (hold_tc)
    );

    pulse_stretcher_counter #(
        .HIGH (GAP_PERIOD - 1)
    ) gap_counter (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (enable),
        .sync_reset   (state != GAP),
        .tc           (gap_tc)
    );

    // An event arriving on the consuming clock is served directly.
    assign request = (pending != '0) || event_i;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && request) begin
                    state_next = ACTIVE;
                    consume    = 1'b1;
                end
            end
            ACTIVE: begin
                if (enable && hold_tc) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (enable && gap_tc) begin
                    if (request) begin
                        state_next = ACTIVE;
                        consume    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next = pending;
        drop         = 1'b0;
        if (event_i && !consume) begin
            if (pending == MAX_C) begin
                drop = 1'b1;
            end else begin
                pending_next = pending + PW'(1);
            end
        end else if (!event_i && consume) begin
            pending_next = pending - PW'(1);
        end
    end

    // NOTE: reset clears the queued events too, so nothing requested before
    // reset can start a pulse afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            overflow <= drop;
        end
    end

    assign data_o     = (state == ACTIVE) ? ~IDLE_VALUE : IDLE_VALUE;
    assign busy_o     = (state != IDLE);
    assign pending_o  = pending;
    assign overflow_o = overflow;

endmodule
